// File: rtl/otf_sd_converter.sv
// On-the-fly conversion of MSB-first borrow-save digit groups into a two's-complement result.
// Q/QM register pair avoids any carry-propagate add across the full result width.
module otf_sd_converter #(
  parameter int unsigned BITS   = 4,
  parameter int unsigned CHUNKS = 4,
  localparam int unsigned W     = BITS * CHUNKS + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_plus,
  input  logic [BITS-1:0] in_minus,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(CHUNKS + 1);
  localparam int unsigned PFX_W = W - BITS;

  typedef enum logic {ACCUM, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]      r_q, w_q_nxt;
  logic [W-1:0]      r_qm, w_qm_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [W-1:0]      r_out_data, w_out_data_nxt;
  logic              r_busy, w_busy_nxt;

  logic              w_acc;
  logic [BITS:0]     w_v;
  logic [BITS:0]     w_vm1;
  logic              w_v_neg;
  logic              w_v_pos;
  logic [W-1:0]      w_q_base;
  logic [W-1:0]      w_qm_base;
  logic [W-1:0]      w_q_new;
  logic [W-1:0]      w_qm_new;

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

  assign w_acc = in_valid & in_ready;

  // Group value in BITS+1 bits; its low BITS bits are exactly the appended field for Q
  assign w_v     = {1'b0, in_plus} - {1'b0, in_minus};
  assign w_vm1   = w_v - (BITS + 1)'(1);
  assign w_v_neg = w_v[BITS];
  assign w_v_pos = !w_v[BITS] && (w_v != '0);

  // Negative digits borrow from QM; positive digits make QM inherit Q's prefix
  assign w_q_base  = w_v_neg ? r_qm : r_q;
  assign w_qm_base = w_v_pos ? r_q  : r_qm;
  assign w_q_new   = {w_q_base[PFX_W-1:0],  w_v[BITS-1:0]};
  assign w_qm_new  = {w_qm_base[PFX_W-1:0], w_vm1[BITS-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_q         <= '0;
      r_qm        <= '1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_q         <= w_q_nxt;
      r_qm        <= w_qm_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_q_nxt         = r_q;
    w_qm_nxt        = r_qm;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    case (r_state)
      ACCUM: begin
        if (w_acc) begin
          w_q_nxt  = w_q_new;
          w_qm_nxt = w_qm_new;
          if (r_cnt == CNT_W'(CHUNKS - 1)) begin
            w_state_nxt     = DONE;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_q_new;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt     = ACCUM;
          w_out_valid_nxt = 1'b0;
          w_q_nxt         = '0;
          w_qm_nxt        = '1;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
    w_busy_nxt = (w_cnt_nxt != '0) || (w_state_nxt == DONE);
  end

endmodule

// File: tb/tb_otf_sd_converter.sv
// Randomized and directed checks of otf_sd_converter against an integer-arithmetic model.
module tb_otf_sd_converter;

  localparam int unsigned TB_BITS   = 4;
  localparam int unsigned TB_CHUNKS = 2;
  localparam int unsigned TB_W      = TB_BITS * TB_CHUNKS + 1;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [TB_BITS-1:0] in_plus;
  logic [TB_BITS-1:0] in_minus;
  logic               out_valid;
  logic               out_ready;
  logic [TB_W-1:0]    out_data;
  logic               busy;

  int n_total;
  int n_bad;

  otf_sd_converter #(.BITS(TB_BITS), .CHUNKS(TB_CHUNKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_plus   (in_plus),
    .in_minus  (in_minus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Value of a full operand: sum of signed group values weighted by 2^(BITS*position)
  function automatic logic [TB_W-1:0] model(input int p[TB_CHUNKS], input int m[TB_CHUNKS]);
    int acc;
    acc = 0;
    for (int k = 0; k < TB_CHUNKS; k++) acc = acc * (1 << TB_BITS) + (p[k] - m[k]);
    return TB_W'(acc);
  endfunction

  // Enters and leaves just after a falling edge
  task automatic send_group(input int p, input int m);
    int n;
    in_plus  = TB_BITS'(p);
    in_minus = TB_BITS'(m);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [TB_W-1:0] exp, input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 32'(out_data), 32'(exp));
    end
    chk({tag, "_rdy_lo"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_hi"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int p[TB_CHUNKS];
    int m[TB_CHUNKS];
    n_total   = 0;
    n_bad     = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_plus   = '0;
    in_minus  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic: v = 2, -5 -> 27, with intermediate Q/QM and 1-cycle latency
    send_group(3, 1);
    chk("s1_q", 32'(dut.r_q), 32'd2);
    chk("s1_qm", 32'(dut.r_qm), 32'd1);
    chk("s1_busy", 32'(busy), 32'd1);
    send_group(0, 5);
    chk("s1_latency", 32'(out_valid), 32'd1);
    chk("s1_busy_done", 32'(busy), 32'd1);
    get_result("s1", 9'h01B, 0);
    chk("s1_busy_idle", 32'(busy), 32'd0);

    // Negative borrow chain
    send_group(0, 1);
    send_group(0, 15);
    get_result("s2", 9'h1E1, 1);

    // Extremes and redundant zero encoding
    send_group(15, 0);  send_group(15, 0);  get_result("max", 9'h0FF, 0);
    send_group(0, 15);  send_group(0, 15);  get_result("min", 9'h101, 0);
    send_group(15, 15); send_group(15, 15); get_result("zero", 9'h000, 0);
    send_group(5, 2);   send_group(1, 0);   get_result("enc_a", 9'h031, 0);
    send_group(15, 12); send_group(9, 8);   get_result("enc_b", 9'h031, 0);

    // Backpressure: new group offered while result is pending must not be consumed
    send_group(2, 0);
    send_group(0, 0);
    in_plus  = 4'h1;
    in_minus = 4'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h20);
      chk("bp_cnt", 32'(dut.r_cnt), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_vld_clr", 32'(out_valid), 32'd0);
    chk("bp_rdy_after", 32'(in_ready), 32'd1);
    chk("bp_cnt_after", 32'(dut.r_cnt), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_group_taken", 32'(dut.r_cnt), 32'd1);
    send_group(0, 0);
    get_result("bp_next", 9'h010, 0);

    // Gapped input, with stray out_ready while nothing is pending
    send_group(3, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_cnt", 32'(dut.r_cnt), 32'd1);
      chk("gap_q", 32'(dut.r_q), 32'd2);
    end
    out_ready = 1'b0;
    send_group(0, 5);
    get_result("gap", 9'h01B, 0);

    // Reset mid-stream discards the partial result
    send_group(3, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_cnt", 32'(dut.r_cnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_q", 32'(dut.r_q), 32'd0);
    send_group(0, 1);
    send_group(0, 15);
    get_result("mrst", 9'h1E1, 0);

    // Reset while a result is pending
    send_group(7, 0);
    send_group(7, 0);
    chk("drst_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("drst_valid", 32'(out_valid), 32'd0);
    chk("drst_data", 32'(out_data), 32'd0);
    chk("drst_rdy", 32'(in_ready), 32'd1);

    // Randomized operands, gaps and consumer stalls
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < TB_CHUNKS; k++) begin
        p[k] = int'($urandom_range(0, 15));
        m[k] = int'($urandom_range(0, 15));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_group(p[k], m[k]);
      end
      get_result("rand", model(p, m), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
